// File: rtl/axis_quad_broadcaster.sv
// AXI4-Stream 1-to-4 broadcaster: one held beat is presented to four outputs, retired once every enabled output accepts.
// Optional per-output beat/drop statistics counters are compiled in with QUAD_BCAST_STATS_EN.
module axis_quad_broadcaster #(
  parameter int DATA_WIDTH   = 256,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            channel_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tlast,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic [DATA_WIDTH-1:0] m01_axis_tdata,
  output logic                  m01_axis_tlast,
  output logic                  m01_axis_tvalid,
  input  logic                  m01_axis_tready,
  output logic [DATA_WIDTH-1:0] m20_axis_tdata,
  output logic                  m20_axis_tlast,
  output logic                  m20_axis_tvalid,
  input  logic                  m20_axis_tready,
  output logic [DATA_WIDTH-1:0] m21_axis_tdata,
  output logic                  m21_axis_tlast,
  output logic                  m21_axis_tvalid,
  input  logic                  m21_axis_tready
`ifdef QUAD_BCAST_STATS_EN
  ,
  input  logic                  stats_clear,
  output logic [31:0]           m00_beat_count,
  output logic [31:0]           m01_beat_count,
  output logic [31:0]           m20_beat_count,
  output logic [31:0]           m21_beat_count,
  output logic [31:0]           drop_count
`endif
);

  localparam int NUM_OUT = 4;

  if (DATA_WIDTH % SAMPLE_WIDTH != 0) begin : g_width_check
    $error("DATA_WIDTH must hold a whole number of samples");
  end

  logic [DATA_WIDTH-1:0] data_reg;
  logic                  last_reg;
  logic [NUM_OUT-1:0]    pending_reg;
  logic [NUM_OUT-1:0]    pending_next;
  logic [NUM_OUT-1:0]    ready_vec;
  logic [NUM_OUT-1:0]    accept;
  logic [NUM_OUT-1:0]    remain;
  logic                  capture;

  assign ready_vec = {m21_axis_tready, m20_axis_tready, m01_axis_tready, m00_axis_tready};
  assign accept    = pending_reg & ready_vec;
  assign remain    = pending_reg & ~accept;

  // Ready may follow the output readies combinationally so the last acceptance and a new capture share a cycle.
  assign s_axis_tready = ~reset & (remain == '0);
  assign capture       = s_axis_tvalid & s_axis_tready;

  always_comb begin
    pending_next = remain;
    if (capture) begin
      pending_next = channel_enable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg <= '0;
      data_reg    <= '0;
      last_reg    <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (capture) begin
        data_reg <= s_axis_tdata;
        last_reg <= s_axis_tlast;
      end
    end
  end

  assign m00_axis_tvalid = pending_reg[0];
  assign m01_axis_tvalid = pending_reg[1];
  assign m20_axis_tvalid = pending_reg[2];
  assign m21_axis_tvalid = pending_reg[3];

  assign m00_axis_tdata = data_reg;
  assign m01_axis_tdata = data_reg;
  assign m20_axis_tdata = data_reg;
  assign m21_axis_tdata = data_reg;

  assign m00_axis_tlast = last_reg;
  assign m01_axis_tlast = last_reg;
  assign m20_axis_tlast = last_reg;
  assign m21_axis_tlast = last_reg;

`ifdef QUAD_BCAST_STATS_EN
  logic [31:0] drop_count_reg;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_beat_cnt
    logic [31:0] count_reg;
    // Clear wins over a same-cycle acceptance; the counter wraps naturally at 32 bits.
    always_ff @(posedge clock) begin
      if (reset || stats_clear) begin
        count_reg <= '0;
      end else if (accept[gi]) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || stats_clear) begin
      drop_count_reg <= '0;
    end else if (capture && (channel_enable == '0)) begin
      drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign m00_beat_count = g_beat_cnt[0].count_reg;
  assign m01_beat_count = g_beat_cnt[1].count_reg;
  assign m20_beat_count = g_beat_cnt[2].count_reg;
  assign m21_beat_count = g_beat_cnt[3].count_reg;
  assign drop_count     = drop_count_reg;
`endif

endmodule

// File: tb/tb_axis_quad_broadcaster.sv
// Directed bench for axis_quad_broadcaster: per-output scoreboard queues fed at input capture, drained at output handshakes.
module tb_axis_quad_broadcaster;
  localparam int DW = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    channel_enable = 4'hF;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m00_tdata, m01_tdata, m20_tdata, m21_tdata;
  logic          m00_tlast, m01_tlast, m20_tlast, m21_tlast;
  logic          m00_tvalid, m01_tvalid, m20_tvalid, m21_tvalid;
  logic [3:0]    mr = 4'hF;
`ifdef QUAD_BCAST_STATS_EN
  logic          stats_clear = 1'b0;
  logic [31:0]   c00, c01, c20, c21, cdrop;
`endif

  logic [3:0]    mv;
  logic [DW-1:0] mdat  [4];
  logic [3:0]    mlast;
  logic [DW:0]   exp_q [4][$];
  int n_cmp = 0;
  int n_err = 0;

  assign mv      = {m21_tvalid, m20_tvalid, m01_tvalid, m00_tvalid};
  assign mlast   = {m21_tlast, m20_tlast, m01_tlast, m00_tlast};
  assign mdat[0] = m00_tdata;
  assign mdat[1] = m01_tdata;
  assign mdat[2] = m20_tdata;
  assign mdat[3] = m21_tdata;

  always #5 clock = ~clock;

  axis_quad_broadcaster #(.DATA_WIDTH(DW), .SAMPLE_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .channel_enable(channel_enable),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m00_axis_tdata(m00_tdata), .m00_axis_tlast(m00_tlast), .m00_axis_tvalid(m00_tvalid), .m00_axis_tready(mr[0]),
    .m01_axis_tdata(m01_tdata), .m01_axis_tlast(m01_tlast), .m01_axis_tvalid(m01_tvalid), .m01_axis_tready(mr[1]),
    .m20_axis_tdata(m20_tdata), .m20_axis_tlast(m20_tlast), .m20_axis_tvalid(m20_tvalid), .m20_axis_tready(mr[2]),
    .m21_axis_tdata(m21_tdata), .m21_axis_tlast(m21_tlast), .m21_axis_tvalid(m21_tvalid), .m21_axis_tready(mr[3])
`ifdef QUAD_BCAST_STATS_EN
    , .stats_clear(stats_clear), .m00_beat_count(c00), .m01_beat_count(c01),
    .m20_beat_count(c20), .m21_beat_count(c21), .drop_count(cdrop)
`endif
  );

  // Scoreboard: drain on output handshakes first, then load the beat the input is handing over this edge.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mv[i] && mr[i]) begin
          n_cmp++;
          assert (exp_q[i].size() != 0) else begin
            n_err++;
            $error("FAIL out%0d_unexpected observed=%h expected=none", i, mdat[i]);
          end
          if (exp_q[i].size() != 0) begin
            logic [DW:0] e;
            e = exp_q[i].pop_front();
            $display("out%0d beat tlast=%0b tdata=%h", i, mlast[i], mdat[i][31:0]);
            assert ({mlast[i], mdat[i]} === e) else begin
              n_err++;
              $error("FAIL out%0d_beat observed=%h expected=%h", i, {mlast[i], mdat[i]}, e);
            end
          end
        end
      end
      if (s_tvalid && s_tready) begin
        for (int i = 0; i < 4; i++) if (channel_enable[i]) exp_q[i].push_back({s_tlast, s_tdata});
      end
    end
  end

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one beat and returns #1 after the capturing edge; reports the cycles it took.
  task automatic send(input logic [DW-1:0] d, input logic l, output int cyc);
    logic hs;
    cyc = 0;
    hs  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!hs && cyc < 50) begin
      @(negedge clock);
      hs = s_tready;
      tick();
      cyc++;
    end
    if (!hs) chk("send_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [7:0] b;

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_tvalid", mv, 0);
    chk("rst_tdata", m20_tdata, 0);
    chk("rst_tlast", mlast, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_s_tready", s_tready, 1);
    tick();

    // 1: full broadcast, back-to-back
    channel_enable = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      send({32{b}}, i == 8, cyc);
      chk("t1_no_stall", cyc, 1);
    end
    chk("t1_tvalid_after_last", mv, 4'hF);
    repeat (3) tick();

    // 2: m20 stalls for 5 cycles, next beat waits and is captured the cycle m20 accepts
    mr = 4'b1011;
    send({32{8'hA5}}, 1'b1, cyc);
    chk("t2_latency", mv, 4'hF);
    s_tvalid = 1'b1;
    s_tdata  = {32{8'h5B}};
    s_tlast  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t2_s_tready_low", s_tready, 0);
      tick();
      chk("t2_only_m20", mv, 4'b0100);
      chk("t2_m20_stable", {m20_tlast, m20_tdata}, {1'b1, {32{8'hA5}}});
    end
    mr = 4'hF;
    @(negedge clock);
    chk("t2_s_tready_release", s_tready, 1);
    tick();
    s_tvalid = 1'b0;
    chk("t2_no_bubble", mv, 4'hF);
    chk("t2_new_data", m00_tdata, {32{8'h5B}});
    repeat (2) tick();

    // 3: partial mask
    channel_enable = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      b = 8'(8'h30 + i);
      send({32{b}}, i == 5, cyc);
      chk("t3_no_stall", cyc, 1);
      chk("t3_mask", mv, 4'b0101);
    end
    repeat (2) tick();

    // 4: mask change while m21 still owes the held beat
    channel_enable = 4'hF;
    mr = 4'b0111;
    send({32{8'hC3}}, 1'b0, cyc);
    channel_enable = 4'h1;
    tick();
    chk("t4_m21_held", mv, 4'b1000);
    s_tvalid = 1'b1;
    s_tdata  = {32{8'hD4}};
    s_tlast  = 1'b1;
    @(negedge clock);
    chk("t4_s_tready_stalled", s_tready, 0);
    tick();
    chk("t4_m21_still_held", {m21_tvalid, m21_tdata}, {1'b1, {32{8'hC3}}});
    mr = 4'hF;
    tick();
    s_tvalid = 1'b0;
    chk("t4_new_mask", mv, 4'b0001);
    chk("t4_new_data", m00_tdata, {32{8'hD4}});
    tick();
    chk("t4_drained", mv, 0);

    // 5: reset while m01 is stalled mid-packet
    channel_enable = 4'hF;
    mr = 4'b1101;
    send({32{8'hE7}}, 1'b0, cyc);
    tick();
    chk("t5_m01_stalled", mv, 4'b0010);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_s_tready_in_reset", s_tready, 0);
    tick();
    reset = 1'b0;
    chk("t5_tvalid_cleared", mv, 0);
    chk("t5_tdata_cleared", m01_tdata, 0);
    chk("t5_tlast_cleared", mlast, 0);
    @(negedge clock);
    chk("t5_s_tready_after", s_tready, 1);
    tick();
    chk("t5_not_represented", mv, 0);
    mr = 4'hF;
    repeat (2) tick();
    chk("t5_still_idle", mv, 0);

`ifdef QUAD_BCAST_STATS_EN
    // 6: statistics counters
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    channel_enable = 4'h3;
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h60 + i);
      send({32{b}}, i == 9, cyc);
    end
    channel_enable = 4'h0;
    for (int i = 0; i < 3; i++) begin
      b = 8'(8'h90 + i);
      send({32{b}}, i == 2, cyc);
      chk("t6_drop_no_stall", cyc, 1);
      chk("t6_drop_no_valid", mv, 0);
    end
    repeat (2) tick();
    chk("t6_m00_count", c00, 10);
    chk("t6_m01_count", c01, 10);
    chk("t6_m20_count", c20, 0);
    chk("t6_m21_count", c21, 0);
    chk("t6_drop_count", cdrop, 3);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("t6_clear", {c00, c01, c20, c21, cdrop}, 0);
`endif

    // Every scoreboarded beat must have been delivered
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("out%0d_queue_empty", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axis_quad_broadcaster.md
Name: axis_quad_broadcaster

Overview:
- AXI4-Stream 1-to-4 fan-out for beamformer sample data: one input stream of packed 16-bit samples is broadcast unchanged to four channel outputs (m00, m01, m20, m21).
- It feeds the four per-channel weighting paths whose results are later summed back by the quad adder.
- Each output handshakes independently. An input beat is retired only when every enabled output has accepted it.

Parameters:
- DATA_WIDTH, 256, tdata width of input and all outputs (16 samples).
- SAMPLE_WIDTH, 16, sample width. Documentation and assertion only; DATA_WIDTH % SAMPLE_WIDTH must be 0.

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- channel_enable  in  4  output mask; bit0=m00, bit1=m01, bit2=m20, bit3=m21.
- s_axis_tdata  in  DATA_WIDTH  input beat.
- s_axis_tlast  in  1  input end-of-packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- mXX_axis_tdata  out  DATA_WIDTH  per output (XX = 00, 01, 20, 21); copy of held beat.
- mXX_axis_tlast  out  1  per output; copy of held tlast.
- mXX_axis_tvalid  out  1  per output valid.
- mXX_axis_tready  in  1  per output ready.

Behaviour:
- State:
  - data_q[DATA_WIDTH], last_q, pending[3:0].
  - pending[i]=1 means output i still owes acceptance of data_q.
- Outputs:
  - mXX_axis_tvalid = pending[i].
  - mXX_axis_tdata = data_q; mXX_axis_tlast = last_q.
  - All outputs are registered. No combinational s->m path.
- Accept and retire:
  - accept[i] = pending[i] & mXX_axis_tready.
  - remain = pending & ~accept.
- s_axis_tready:
  - ~reset & (remain == 0).
  - This is a combinational m-tready -> s-tready path. It is permitted and must not depend on s_axis_tvalid.
- Capture (s_axis_tvalid & s_axis_tready):
  - data_q <= s_axis_tdata; last_q <= s_axis_tlast.
  - pending <= channel_enable, sampled in the capture cycle.
- Otherwise: pending <= remain; data_q and last_q hold.
- Latency and throughput:
  - Latency is 1 cycle, input handshake to mXX tvalid.
  - Sustains 1 beat/cycle when all enabled outputs are ready.
- Independence: outputs that have already accepted drop tvalid. Stalled outputs keep tvalid=1 with stable tdata and tlast until they accept (AXI stability rule).
- Mask rules:
  - channel_enable is sampled only at capture. Changes while a beat is pending do not alter the current pending.
  - channel_enable==0: beats are accepted at 1/cycle and discarded; pending stays 0.
- Simultaneous events: the last pending output accepting in the same cycle as a new input capture is legal. pending is reloaded that cycle with no bubble.
- Reset:
  - pending=0, data_q=0, last_q=0.
  - Result: all mXX tvalid=0, tdata=0, tlast=0, and s_axis_tready=0 while reset=1.
  - Reset mid-operation drops the held beat with no partial delivery afterward. s_axis_tready rises the cycle after reset deasserts.
- No internal state machine beyond the pending mask. No FIFO depth beyond one beat.

Optional Feature:
- Macro: QUAD_BCAST_STATS_EN.
- Defined: adds the following.
  - Input stats_clear (1).
  - Outputs m00_beat_count, m01_beat_count, m20_beat_count, m21_beat_count (32 each) and drop_count (32).
  - Each beat counter increments on accept[i].
  - drop_count increments on a captured beat with channel_enable==0.
  - Counters wrap at 2^32-1 -> 0.
  - stats_clear (synchronous) zeroes all counters and takes priority over a same-cycle increment.
  - Reset zeroes all counters.
- Undefined: these ports and counters do not exist. Datapath behaviour is identical.

Test Plan:
1. Enable=4'hF, all tready=1, send 8 beats tdata=i*0x0101.., tlast on beat 8:
   - each output sees the same 8 beats 1 cycle later, back-to-back, tlast only on beat 8;
   - s_axis_tready stays 1.
2. Enable=4'hF, m20 tready=0 for 5 cycles, others=1, one beat 0xA5..:
   - m00, m01, m21 tvalid pulse for 1 cycle;
   - m20 tvalid held 5 cycles with data stable;
   - s_axis_tready=0 until the cycle m20 accepts, then the next beat is captured with no bubble.
3. Enable=4'b0101, all ready:
   - only m00 and m20 assert tvalid;
   - m01 and m21 tvalid stay 0;
   - throughput 1/cycle.
4. Change enable 4'hF->4'h1 while a beat is pending on m21:
   - m21 still delivers the held beat;
   - the next captured beat appears only on m00.
5. Assert reset for 1 cycle while m01 is stalled mid-packet:
   - all tvalid=0 and tdata=0 next cycle;
   - s_axis_tready=0 during reset, 1 after;
   - the old beat is never re-presented.
6. (QUAD_BCAST_STATS_EN) 10 beats with enable=4'h3, then 3 beats with enable=0:
   - m00/m01 counts=10, m20/m21=0, drop_count=3;
   - stats_clear -> all 0.
